load_store_unit: RTL
====================

# load_store_unit

Pipeline-side initiator for the word-organised data memory. It accepts one load or store per request from the execute/memory stage and decodes the RISC-V width (`funct3`). It drives the memory's `MemRead`/`MemWrite`/address/data lines, performing read-modify-write for sub-word stores and lane-extract plus sign/zero extension for loads. It returns a single-cycle response with a ready/valid handshake so the pipeline can stall on it.

## Interface
- `ADDR_W`, 8: byte-address bits used; memory word address is `ADDR_W-2` bits (64 words at default).
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; request accepted on the edge where `req_valid & req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- `req_addr`  in  32  byte address; bits above `ADDR_W-1` ignored (wrap).
- `req_wdata`  in  32  store data, low bits used for B/H.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data while `resp_valid`; 0 for stores and otherwise.
- `resp_err`  out  1  with `resp_valid`: access rejected (see Configuration).
- `mem_read`  out  1  to memory `MemRead`.
- `mem_write`  out  1  to memory `MemWrite`.
- `mem_addr`  out  ADDR_W-2  word address = captured `addr[ADDR_W-1:2]`.
- `mem_wdata`  out  32  word to write.
- `mem_rdata`  in  32  memory read data (combinational, valid in the same cycle `mem_read` is high).

## Operation
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE: on accept, capture `we`, `funct3`, `addr`, `wdata`. Illegal `funct3` (011, 110, 111, or 100/101 with store) → RESP with error. Load → LOAD. Store W → WRITE with `mem_wdata = wdata`. Store B/H → RMW_RD.
- LOAD: `mem_read=1`; select lane by `addr[1:0]` (B) or `addr[1]` (H); sign-extend for B/H, zero-extend for BU/HU; register into `resp_rdata`; → RESP.
- RMW_RD: `mem_read=1`; register `mem_rdata` with the selected byte/halfword lane replaced by `wdata[7:0]`/`wdata[15:0]`; → WRITE.
- WRITE: `mem_write=1`, `mem_wdata` = merged or full word; memory commits at the end of this cycle; → RESP.
- RESP: `resp_valid=1` for exactly one cycle; → IDLE.
- `mem_read` and `mem_write` are never high together. Both are 0 outside LOAD/RMW_RD/WRITE, and `mem_wdata` is 0 outside WRITE.
- Requests arriving while `req_ready=0` are ignored; the requester holds them.

## Timing
- Reset values: state IDLE, `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `mem_read=0`, `mem_write=0`, `mem_addr=0`, `mem_wdata=0`.
- Accept at edge N. Load/store-word: `resp_valid` during cycle N+2. Sub-word store: `resp_valid` during cycle N+3. Error: `resp_valid` during cycle N+1.
- Next accept is possible in the cycle after RESP, so throughput is one request per 3 (word) or 4 (sub-word) cycles.
- Reset mid-operation: all outputs drop immediately (async). A write in progress is not committed if `rst` rises before the WRITE-cycle edge. No response is produced for the aborted request.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: H/HU with `addr[0]=1`, or W with `addr[1:0]!=0`, completes as an error: no memory access, `resp_err=1`, `resp_rdata=0`, response in cycle N+1.
- Not defined: no alignment check. H uses lane `addr[1]` ignoring `addr[0]`; W ignores `addr[1:0]`. `resp_err` is raised only for illegal `funct3`.

## Test plan
- Word 1 preloaded 0x8040_FF7F. LB @4 → 0x0000_007F; LB @5 → 0xFFFF_FFFF; LBU @5 → 0x0000_00FF; LH @6 → 0xFFFF_8040; LHU @6 → 0x0000_8040. Each response arrives 2 cycles after accept.
- Word 2 = 0x1122_3344. SB @9 data 0xAB → word 2 = 0x1122_AB44; SH @10 data 0xBEEF → 0xBEEF_AB44. Bench checks the RMW_RD, WRITE, RESP sequence and that `mem_read`/`mem_write` are never overlapped.
- SW @0 data 0xDEAD_BEEF, then LW @0 → 0xDEAD_BEEF. Check `req_ready` is low for 2 cycles after each accept.
- With `LSU_MISALIGN_TRAP_EN`: LW @2 → `resp_err=1` 1 cycle after accept, no `mem_read`. Without it: LW @2 returns word 0.
- `funct3`=011 load, or SB with `funct3`=100 → `resp_err=1`, memory untouched.
- Assert `rst` during the WRITE cycle of SW @12 data 0xFFFF_FFFF → word 3 is unchanged, all outputs at reset values, and the next LW @12 works normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-organised data memory: sub-word read-modify-write and load extension.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned H/HU/W accesses into error responses.
module load_store_unit #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned WA = ADDR_W - 2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_RESP
    } state_e;

    state_e         state_q, state_d;
    logic [2:0]     funct3_q, funct3_d;
    logic [1:0]     lane_q, lane_d;
    logic [15:0]    wdata_q, wdata_d;
    logic [WA-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]    mem_wdata_q, mem_wdata_d;
    logic [31:0]    resp_rdata_q, resp_rdata_d;
    logic           resp_err_q, resp_err_d;
    logic           req_ready_q, resp_valid_q, mem_read_q, mem_write_q;

    logic           bad_f3_c;
    logic           misalign_c;
    logic [7:0]     ld_byte_c;
    logic [15:0]    ld_half_c;
    logic [31:0]    merged_c;
    logic           unused_c;

    assign unused_c = ^req_addr[31:ADDR_W];

    // Request decode: unknown widths, and unsigned widths on a store, are rejected
    always_comb begin
        bad_f3_c = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: bad_f3_c = 1'b0;
            F3_BU, F3_HU:     bad_f3_c = req_we;
            default:          bad_f3_c = 1'b1;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_c = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0])
                   || ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
        misalign_c = 1'b0;
`endif
    end

    // Lane extract for loads and lane merge for sub-word stores
    always_comb begin
        ld_byte_c = mem_rdata[{lane_q, 3'b000} +: 8];
        ld_half_c = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        merged_c  = mem_rdata;
        if (funct3_q == F3_B) begin
            merged_c[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else if (lane_q[1]) begin
            merged_c[31:16] = wdata_q;
        end else begin
            merged_c[15:0] = wdata_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = 32'h0;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    funct3_d   = req_funct3;
                    lane_d     = req_addr[1:0];
                    wdata_d    = req_wdata[15:0];
                    mem_addr_d = req_addr[ADDR_W-1:2];
                    if (bad_f3_c || misalign_c) begin
                        state_d    = S_RESP;
                        resp_err_d = 1'b1;
                    end else if (!req_we) begin
                        state_d = S_LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_d     = S_WRITE;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                state_d = S_RESP;
                case (funct3_q)
                    F3_B:    resp_rdata_d = {{24{ld_byte_c[7]}}, ld_byte_c};
                    F3_BU:   resp_rdata_d = {24'h0, ld_byte_c};
                    F3_H:    resp_rdata_d = {{16{ld_half_c[15]}}, ld_half_c};
                    F3_HU:   resp_rdata_d = {16'h0, ld_half_c};
                    F3_W:    resp_rdata_d = mem_rdata;
                    default: resp_rdata_d = 32'h0;
                endcase
            end
            S_RMW_RD: begin
                state_d     = S_WRITE;
                mem_wdata_d = merged_c;
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and memory strobes are registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            funct3_q     <= 3'b000;
            lane_q       <= 2'b00;
            wdata_q      <= 16'h0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            funct3_q     <= funct3_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            req_ready_q  <= (state_d == S_IDLE);
            resp_valid_q <= (state_d == S_RESP);
            mem_read_q   <= (state_d == S_LOAD) || (state_d == S_RMW_RD);
            mem_write_q  <= (state_d == S_WRITE);
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
